// File: rtl/adrv9001_tx_pattern_pkg.sv
// Shared definitions for the ADRV9001 TX AXI-Stream pattern source:
// FSM state encodings, pattern mode codes and the PN15 generator constants.
package adrv9001_tx_pattern_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EN_WAIT  = 2'd1,
        ST_STREAM   = 2'd2,
        ST_DIS_WAIT = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        MODE_RAMP   = 2'd0,
        MODE_CONST  = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_PN15   = 2'd3
    } tx_mode_e;

    // x^15 + x^14 + 1, left-shifting; feedback taps are state bits 14 and 13
    localparam logic [14:0] PN15_SEED   = 15'h7FFF;
    localparam int unsigned PN15_TAP_HI = 32'd14;
    localparam int unsigned PN15_TAP_LO = 32'd13;

    // One left-shift step of the PN15 register
    function automatic logic [14:0] pn15_next(input logic [14:0] s);
        return {s[13:0], s[PN15_TAP_HI] ^ s[PN15_TAP_LO]};
    endfunction

    // Sample word for a PN15 state: I = {0,s}, Q = ~I
    function automatic logic [31:0] pn15_word(input logic [14:0] s);
        logic [15:0] i_word;
        i_word = {1'b0, s};
        return {i_word, ~i_word};
    endfunction

endpackage

// File: rtl/adrv9001_prbs15.sv
// PN15 state register for the TX pattern source. Reloads the seed on reset
// or on a seed strobe and steps once per advance strobe.
module adrv9001_prbs15
    import adrv9001_tx_pattern_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_i,
    input  logic        advance_i,
    output logic [14:0] state_o
);

    logic [14:0] state_q;

    // LFSR state: seed on reset/seed strobe, shift on advance, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PN15_SEED;
        end else if (seed_i) begin
            state_q <= PN15_SEED;
        end else if (advance_i) begin
            state_q <= pn15_next(state_q);
        end else begin
            state_q <= state_q;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/adrv9001_axis_tx_pattern.sv
// ADRV9001 TX AXI-Stream test-pattern source. Frames each burst with
// adrv9001_enable: a lead-in of max(enable_cnt,1) cycles, the data beats,
// then a tail of max(disable_cnt,1) cycles before returning to idle.
// Optional feature macro: ADRV9001_TX_PATTERN_PN15_EN (mode 3 = PN15;
// when undefined no LFSR is built and mode 3 produces the ramp).
module adrv9001_axis_tx_pattern
    import adrv9001_tx_pattern_pkg::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int RAMP_STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pl_en,
    input  logic [1:0]           mode,
    input  logic [31:0]          const_data,
    input  logic [CNT_WIDTH-1:0] burst_len,
    input  logic [CNT_WIDTH-1:0] enable_cnt,
    input  logic [CNT_WIDTH-1:0] disable_cnt,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 adrv9001_enable,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] sample_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [15:0]          RAMP_INC = 16'(RAMP_STEP);

    // Lead/tail counters count down to zero, so a programmed 0 behaves as 1
    function automatic logic [CNT_WIDTH-1:0] wait_load(input logic [CNT_WIDTH-1:0] c);
        return (c == CNT_ZERO) ? CNT_ZERO : (c - CNT_ONE);
    endfunction

    tx_state_e              state_q;
    tx_mode_e               mode_q;
    logic [31:0]            const_q;
    logic [CNT_WIDTH-1:0]   burst_q;
    logic [CNT_WIDTH-1:0]   dis_q;
    logic [CNT_WIDTH-1:0]   wait_q;
    logic [CNT_WIDTH-1:0]   sample_cnt_q;
    logic [15:0]            ramp_q;
    logic                   tog_q;
    logic [31:0]            tdata_q;
    logic                   tvalid_q;
    logic                   enable_q;
    logic                   busy_q;
    logic                   done_q;

    logic [15:0]            ramp_d;
    logic                   tog_d;
    logic [31:0]            head_d;
    logic [31:0]            beat_d;
    logic [CNT_WIDTH-1:0]   sample_cnt_d;
    logic                   beat_acc_s;
    logic                   last_beat_s;
    logic                   start_s;

`ifdef ADRV9001_TX_PATTERN_PN15_EN
    logic [14:0]            pn_s;
    logic [14:0]            pn_d;

    adrv9001_prbs15 u_prbs15 (
        .clk       (clk),
        .rst       (rst),
        .seed_i    (start_s),
        .advance_i (beat_acc_s),
        .state_o   (pn_s)
    );

    // Next PN state, used to preload the beat that follows an acceptance
    always_comb begin
        pn_d = pn15_next(pn_s);
    end
`endif

    // Handshake, start and burst-termination decodes
    always_comb begin
        start_s      = (state_q == ST_IDLE) & pl_en;
        beat_acc_s   = tvalid_q & m_axis_tready;
        sample_cnt_d = sample_cnt_q + CNT_ONE;
        if (burst_q != CNT_ZERO) begin
            last_beat_s = (sample_cnt_d == burst_q);
        end else begin
            last_beat_s = 1'b0;
        end
    end

    // First beat of a burst, built from the freshly cleared generator state
    always_comb begin
        head_d = {ramp_q, 16'h0000 - ramp_q};
        case (mode_q)
            MODE_CONST:  head_d = const_q;
            MODE_TOGGLE: head_d = tog_q ? ~const_q : const_q;
`ifdef ADRV9001_TX_PATTERN_PN15_EN
            MODE_PN15:   head_d = pn15_word(pn_s);
`endif
            default:     head_d = {ramp_q, 16'h0000 - ramp_q};
        endcase
    end

    // Beat that replaces the current one once it is accepted
    always_comb begin
        ramp_d = ramp_q + RAMP_INC;
        tog_d  = ~tog_q;
        beat_d = {ramp_d, 16'h0000 - ramp_d};
        case (mode_q)
            MODE_CONST:  beat_d = const_q;
            MODE_TOGGLE: beat_d = tog_d ? ~const_q : const_q;
`ifdef ADRV9001_TX_PATTERN_PN15_EN
            MODE_PN15:   beat_d = pn15_word(pn_d);
`endif
            default:     beat_d = {ramp_d, 16'h0000 - ramp_d};
        endcase
    end

    // Burst sequencer with registered stream, enable and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_RAMP;
            const_q      <= 32'h0000_0000;
            burst_q      <= CNT_ZERO;
            dis_q        <= CNT_ZERO;
            wait_q       <= CNT_ZERO;
            sample_cnt_q <= CNT_ZERO;
            ramp_q       <= 16'h0000;
            tog_q        <= 1'b0;
            tdata_q      <= 32'h0000_0000;
            tvalid_q     <= 1'b0;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pl_en) begin
                        state_q      <= ST_EN_WAIT;
                        mode_q       <= tx_mode_e'(mode);
                        const_q      <= const_data;
                        burst_q      <= burst_len;
                        dis_q        <= disable_cnt;
                        wait_q       <= wait_load(enable_cnt);
                        sample_cnt_q <= CNT_ZERO;
                        ramp_q       <= 16'h0000;
                        tog_q        <= 1'b0;
                        enable_q     <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                ST_EN_WAIT: begin
                    if (wait_q == CNT_ZERO) begin
                        state_q  <= ST_STREAM;
                        tvalid_q <= 1'b1;
                        tdata_q  <= head_d;
                    end else begin
                        wait_q <= wait_q - CNT_ONE;
                    end
                end
                ST_STREAM: begin
                    // A presented beat is never withdrawn: pl_en is only
                    // honoured on the edge that accepts the pending beat.
                    if (beat_acc_s) begin
                        sample_cnt_q <= sample_cnt_d;
                        ramp_q       <= ramp_d;
                        tog_q        <= tog_d;
                        if (last_beat_s || !pl_en) begin
                            state_q  <= ST_DIS_WAIT;
                            tvalid_q <= 1'b0;
                            wait_q   <= wait_load(dis_q);
                        end else begin
                            tdata_q <= beat_d;
                        end
                    end
                end
                ST_DIS_WAIT: begin
                    if (wait_q == CNT_ZERO) begin
                        state_q  <= ST_IDLE;
                        enable_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    tvalid_q <= 1'b0;
                    enable_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_tdata    = tdata_q;
    assign m_axis_tvalid   = tvalid_q;
    assign adrv9001_enable = enable_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign sample_cnt      = sample_cnt_q;

endmodule

// File: tb/tb_adrv9001_axis_tx_pattern.sv
// Self-checking bench for adrv9001_axis_tx_pattern. Expected beats are
// queued when a burst is started and compared as the DUT hands them over.
module tb_adrv9001_axis_tx_pattern;

    logic        clk = 1'b0;
    logic        rst;
    logic        pl_en;
    logic [1:0]  mode;
    logic [31:0] const_data;
    logic [15:0] burst_len;
    logic [15:0] enable_cnt;
    logic [15:0] disable_cnt;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        adrv9001_enable;
    logic        busy;
    logic        done;
    logic [15:0] sample_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] sb_q[$];
    int          acc_cnt, done_cnt, first_tv, last_tv, en_on, en_off, done_cyc, k0;
    bit          tv_seen, done_seen, pend, prev_en;
    logic [31:0] pend_data;

    adrv9001_axis_tx_pattern #(.CNT_WIDTH(16), .RAMP_STEP(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .pl_en           (pl_en),
        .mode            (mode),
        .const_data      (const_data),
        .burst_len       (burst_len),
        .enable_cnt      (enable_cnt),
        .disable_cnt     (disable_cnt),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .adrv9001_enable (adrv9001_enable),
        .busy            (busy),
        .done            (done),
        .sample_cnt      (sample_cnt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor on the falling edge: handshake, scoreboard and event times
    initial forever begin
        logic [31:0] exp_beat;
        @(negedge clk);
        if (rst) begin
            pend    = 1'b0;
            prev_en = 1'b0;
        end else begin
            if (pend) begin
                chk_val("hold_valid", 32'(m_axis_tvalid), 32'd1);
                chk_val("hold_data", m_axis_tdata, pend_data);
            end
            if (adrv9001_enable && !prev_en) en_on = cyc;
            if (!adrv9001_enable && prev_en) en_off = cyc;
            prev_en = adrv9001_enable;
            if (m_axis_tvalid) begin
                if (!tv_seen) begin
                    tv_seen  = 1'b1;
                    first_tv = cyc;
                end
                last_tv = cyc;
            end
            if (done) begin
                done_seen = 1'b1;
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                acc_cnt++;
                if (sb_q.size() == 0) begin
                    chk_val("sb_extra_beat", 32'(sb_q.size()), 32'd1);
                end else begin
                    exp_beat = sb_q.pop_front();
                    chk_val("beat_data", m_axis_tdata, exp_beat);
                end
            end
            pend      = m_axis_tvalid && !m_axis_tready;
            pend_data = m_axis_tdata;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a burst; config inputs are scrambled after the start edge
    task automatic start_burst(input logic [1:0] m, input logic [31:0] c,
                               input logic [15:0] bl, input logic [15:0] ec,
                               input logic [15:0] dc);
        mode        = m;
        const_data  = c;
        burst_len   = bl;
        enable_cnt  = ec;
        disable_cnt = dc;
        tv_seen     = 1'b0;
        done_seen   = 1'b0;
        acc_cnt     = 0;
        done_cnt    = 0;
        en_on       = -1;
        en_off      = -1;
        first_tv    = -1;
        last_tv     = -1;
        done_cyc    = -1;
        pl_en       = 1'b1;
        k0          = cyc + 1;
        tick();
        mode        = 2'd2;
        const_data  = 32'hDEAD_BEEF;
        burst_len   = 16'd1;
        enable_cnt  = 16'd9;
        disable_cnt = 16'd9;
    endtask

    // Wait (bounded) for done; release pl_en once the stream has ended
    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin
            tick();
            n++;
            if (tv_seen && !m_axis_tvalid) pl_en = 1'b0;
        end
        chk_val({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        pl_en = 1'b0;
        tick();
        chk_val({tag, "_busy_idle"}, 32'(busy), 32'd0);
        chk_val({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        chk_val({tag, "_sb_left"}, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_acc(input int target);
        int n = 0;
        while (acc_cnt < target && n < 200) begin
            tick();
            n++;
        end
        chk_val("acc_wait", 32'(acc_cnt >= target), 32'd1);
    endtask

    initial begin
        rst = 1'b1; pl_en = 1'b0; mode = 2'd0; const_data = 32'h0;
        burst_len = 16'd0; enable_cnt = 16'd0; disable_cnt = 16'd0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        chk_val("rst_tdata", m_axis_tdata, 32'h0);
        chk_val("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk_val("rst_enable", 32'(adrv9001_enable), 32'd0);
        chk_val("rst_busy", 32'(busy), 32'd0);
        chk_val("rst_done", 32'(done), 32'd0);
        chk_val("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // 1: ramp burst of 4 with 3-cycle lead and 2-cycle tail
        sb_q = '{32'h0000_0000, 32'h0001_FFFF, 32'h0002_FFFE, 32'h0003_FFFD};
        start_burst(2'd0, 32'h0, 16'd4, 16'd3, 16'd2);
        wait_done("t1", 100);
        chk_val("t1_en_on", 32'(en_on), 32'(k0));
        chk_val("t1_first_tvalid", 32'(first_tv), 32'(k0 + 3));
        chk_val("t1_last_tvalid", 32'(last_tv), 32'(k0 + 6));
        chk_val("t1_en_off", 32'(en_off), 32'(k0 + 9));
        chk_val("t1_done_at", 32'(done_cyc), 32'(k0 + 9));
        chk_val("t1_sample_cnt", 32'(sample_cnt), 32'd4);
        tick();

        // 2: constant burst of 3, beat 2 stalled for 5 cycles
        sb_q = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
        start_burst(2'd1, 32'h1234_5678, 16'd3, 16'd1, 16'd1);
        wait_acc(1);
        m_axis_tready = 1'b0;
        repeat (5) tick();
        m_axis_tready = 1'b1;
        wait_done("t2", 100);
        chk_val("t2_accepted", 32'(acc_cnt), 32'd3);
        chk_val("t2_sample_cnt", 32'(sample_cnt), 32'd3);
        tick();

        // 3: continuous toggle, pl_en dropped while beat 6 is stalled
        sb_q = '{32'h1234_5678, 32'hEDCB_A987, 32'h1234_5678,
                 32'hEDCB_A987, 32'h1234_5678, 32'hEDCB_A987};
        start_burst(2'd2, 32'h1234_5678, 16'd0, 16'd2, 16'd1);
        wait_acc(5);
        m_axis_tready = 1'b0;
        tick();
        pl_en = 1'b0;
        repeat (3) tick();
        chk_val("t3_stall_valid", 32'(m_axis_tvalid), 32'd1);
        m_axis_tready = 1'b1;
        wait_done("t3", 100);
        chk_val("t3_accepted", 32'(acc_cnt), 32'd6);
        tick();

        // 4: mode 3 (PN15 when built in, otherwise ramp)
`ifdef ADRV9001_TX_PATTERN_PN15_EN
        sb_q = '{32'h7FFF_8000, 32'h7FFE_8001, 32'h7FFC_8003};
`else
        sb_q = '{32'h0000_0000, 32'h0001_FFFF, 32'h0002_FFFE};
`endif
        start_burst(2'd3, 32'h0, 16'd3, 16'd1, 16'd1);
        wait_done("t4", 100);
        tick();

        // 5: reset in the middle of a continuous ramp stream
        sb_q = '{32'h0000_0000, 32'h0001_FFFF};
        start_burst(2'd0, 32'h0, 16'd0, 16'd1, 16'd1);
        wait_acc(2);
        rst = 1'b1;
        tick();
        chk_val("t5_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk_val("t5_enable", 32'(adrv9001_enable), 32'd0);
        chk_val("t5_busy", 32'(busy), 32'd0);
        chk_val("t5_done", 32'(done), 32'd0);
        rst = 1'b0;
        pl_en = 1'b0;
        repeat (3) tick();
        chk_val("t5_no_done", 32'(done_cnt), 32'd0);
        chk_val("t5_accepted", 32'(acc_cnt), 32'd2);
        sb_q = '{32'h0000_0000, 32'h0001_FFFF};
        start_burst(2'd0, 32'h0, 16'd2, 16'd1, 16'd1);
        wait_done("t5b", 100);
        tick();

        // 6: zero lead/tail counts give one cycle each
        sb_q = '{32'h0000_0000, 32'h0001_FFFF};
        start_burst(2'd0, 32'h0, 16'd2, 16'd0, 16'd0);
        wait_done("t6", 100);
        chk_val("t6_en_on", 32'(en_on), 32'(k0));
        chk_val("t6_first_tvalid", 32'(first_tv), 32'(k0 + 1));
        chk_val("t6_last_tvalid", 32'(last_tv), 32'(k0 + 2));
        chk_val("t6_en_off", 32'(en_off), 32'(k0 + 4));
        chk_val("t6_done_at", 32'(done_cyc), 32'(k0 + 4));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
